flat_trace_serializer: RTL and testbench
========================================

Name: flat_trace_serializer

Overview:
- Response-side counterpart of the stimulus harness that drives a flat input bus into `top` each cycle.
- Captures the wide `out_flat` response vector on request and time-stamps it with a free-running cycle counter.
- Buffers captured records in a small FIFO and serializes each one onto a narrow valid/ready stream as 1 header beat plus ceil(W_IN/LANE_W) data beats.
- Lets a log sink or a host link consume DUT responses without per-cycle $write dumping.

Parameters:
- W_IN, 159, width of the captured flat response vector.
- LANE_W, 32, stream beat width; also the cycle-stamp width.
- DEPTH, 4, FIFO depth in records; power of two, >= 2.
- NBEATS, derived = ceil(W_IN/LANE_W) (5 at defaults), data beats per record.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- cap_valid  in  1  capture `flat_in` this cycle.
- flat_in  in  W_IN  response vector (`out_flat` of `top`).
- s_valid  out  1  stream beat valid.
- s_ready  in  1  sink accepts the beat.
- s_data  out  LANE_W  beat payload.
- s_first  out  1  high on the header beat.
- s_last  out  1  high on the final data beat of a record.
- overflow  out  1  sticky; set on the first dropped capture.
- drop_cnt  out  16  dropped captures, saturating at 0xFFFF.
- cyc_cnt  out  LANE_W  free-running cycle counter.

Behaviour:
- Reset
  - rst sampled high at a posedge clears everything: cyc_cnt=0, FIFO empty, beat index=0, FSM=IDLE, s_valid/s_first/s_last=0, s_data=0, overflow=0, drop_cnt=0.
  - Reset mid-record discards the partial record; no completion beats follow.
  - The sink must treat a rst pulse as a stream restart.
- Cycle counter
  - Increments by 1 every non-reset cycle and wraps 2^LANE_W-1 -> 0.
  - The stamp stored with a capture is the cyc_cnt value in the capture cycle.
- Capture
  - When cap_valid=1 at a posedge and the FIFO is not full, push {stamp, flat_in}.
  - If the FIFO is full, the push is still accepted when the same edge pops the last beat of the head record (simultaneous pop+push on full is legal).
  - Otherwise the capture is dropped: overflow<=1 and drop_cnt increments (saturating).
- Latency: a capture at edge k gives s_valid=1 in cycle k+1, provided the FIFO was empty and the FSM was in IDLE.
- FSM states
  - IDLE: FIFO empty, s_valid=0. Goes to HDR when the FIFO is non-empty.
  - HDR: s_valid=1, s_first=1, s_data=stamp of the head record. On s_ready, go to DATA with beat index=0.
  - DATA: s_data = head vector bits [LANE_W*(i+1)-1 : LANE_W*i] for beat i, LSB slice first. The final beat is zero-padded above bit W_IN-1; s_last=1 on beat NBEATS-1.
  - On a handshake at beat NBEATS-1, pop the record, then go to HDR if another record is queued, else IDLE. There is no bubble between records.
- Handshake rules
  - Standard valid/ready: transfer when s_valid & s_ready.
  - While s_valid=1 and s_ready=0, s_data/s_first/s_last hold stable.
  - s_valid never drops without a transfer except on rst.
- Outputs are driven from state registers and the FIFO head; there is no combinational path from s_ready to s_valid.
- Full/empty: FIFO uses pointers one bit wider than log2(DEPTH); full = MSBs differ and low bits equal.

Decomposition:
- Shared package `trace_pkg`
  - LANE_W
  - NBEATS function ceil_div(W_IN, LANE_W)
  - FSM state enum {IDLE, HDR, DATA}
  - record struct {stamp, vec}
- One sub-module: `trace_rec_fifo`, a parameterised synchronous FIFO with push, pop, full, empty and head data, plus same-cycle push-on-pop when full.

Test Plan:
1. Single capture: rst 2 cycles, then cap_valid=1 at cycle 5 with flat_in = 159'h1 << 158 -> 6 beats: header 0x00000005 (s_first), then 0x00000000 x4, then 0x40000000 (s_last); s_valid low afterwards.
2. Back-pressure: same record with s_ready toggled 1,0,0,1,… -> beat contents and order identical to scenario 1; s_data stable during every stall.
3. Overflow: s_ready=0 and cap_valid=1 for 6 cycles -> 4 records stored, overflow=1, drop_cnt=2; raise s_ready -> 24 beats with stamps k..k+3, contiguous.
4. Full + simultaneous pop/push: FIFO full and the last beat of the head record handshakes in the same cycle as cap_valid=1 -> capture accepted, drop_cnt unchanged.
5. Reset mid-record: rst asserted after 3 beats -> next cycle s_valid=0, drop_cnt=0, cyc_cnt=0; a new capture then emits header stamp 0x00000001 if captured 1 cycle after rst deasserts.
6. Counter wrap: force cyc_cnt near 0xFFFFFFFF via a long run or small LANE_W build (LANE_W=8, W_IN=20) -> stamps 0xFF then 0x00; NBEATS=3 with zero-padded top beat.

Source files
------------

// File: rtl/flat_trace_serializer_pkg.sv
// Shared types and helpers for the flat trace serializer: state encoding,
// default record layout and the beat-count helper.
package trace_pkg;

  localparam int TRACE_LANE_W = 32;
  localparam int TRACE_W_IN   = 159;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_LANE_W-1:0] stamp;
    logic [TRACE_W_IN-1:0]   vec;
  } trace_rec_t;

endpackage

// File: rtl/flat_trace_serializer_if.sv
// Narrow valid/ready trace stream between the serializer (master) and a
// log sink or host link (slave).
interface flat_trace_serializer_if #(
  parameter int LANE_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [LANE_W-1:0] s_data;
  logic              s_first;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_first, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_first, input s_last, output s_ready);
endinterface

// File: rtl/flat_trace_serializer_rec_fifo.sv
// Synchronous record FIFO with wrap-bit pointers; exposes the head and the
// record behind it so the reader can chain records without a bubble.
module trace_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             two_plus,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_next
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      rd_ptr_inc;

  assign count      = wr_ptr - rd_ptr;
  assign rd_ptr_inc = rd_ptr + (AW + 1)'(1);
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign two_plus   = (count >= (AW + 1)'(2));
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_next  = mem[rd_ptr_inc[AW-1:0]];

  // A push on full only happens alongside a pop, so it reuses the slot being freed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
    end
  end

endmodule

// File: rtl/flat_trace_serializer.sv
// Captures a wide response vector with a cycle stamp, queues it, and emits
// each record as one header beat plus NBEATS LSB-first data beats.
module flat_trace_serializer
  import trace_pkg::*;
#(
  parameter int W_IN   = TRACE_W_IN,
  parameter int LANE_W = TRACE_LANE_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid,
  input  logic [W_IN-1:0]         flat_in,
  flat_trace_serializer_if.master strm,
  output logic                    overflow,
  output logic [15:0]             drop_cnt,
  output logic [LANE_W-1:0]       cyc_cnt
);
  localparam int NBEATS = ceil_div(W_IN, LANE_W);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PW     = NBEATS * LANE_W;
  localparam int RW     = LANE_W + W_IN;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef struct packed {
    logic [LANE_W-1:0] stamp;
    logic [W_IN-1:0]   vec;
  } rec_t;

  trace_state_e      state;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     beat_inc;
  logic              full, empty, two_plus, push, pop, more;
  rec_t              head, head_next, next_rec;
  logic [PW-1:0]     pad_head;
  logic [LANE_W-1:0] slice_inc;

  trace_rec_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       ({cyc_cnt, flat_in}),
    .full      (full),
    .empty     (empty),
    .two_plus  (two_plus),
    .head      (head),
    .head_next (head_next)
  );

  assign pop      = (state == DATA) && strm.s_ready && (beat == LAST_BEAT);
  assign push     = cap_valid && (!full || pop);
  assign pad_head = PW'(head.vec);
  assign beat_inc = beat + BW'(1);

  // Record that becomes the head after the current one pops; a same-edge
  // capture counts when it is the only one left.
  always_comb begin
    more     = 1'b0;
    next_rec = head;
    if (two_plus) begin
      more     = 1'b1;
      next_rec = head_next;
    end else if (push) begin
      more     = 1'b1;
      next_rec = {cyc_cnt, flat_in};
    end else begin
      more     = 1'b0;
      next_rec = head;
    end
  end

  always_comb begin
    slice_inc = '0;
    if (beat != LAST_BEAT) begin
      slice_inc = pad_head[LANE_W*beat_inc +: LANE_W];
    end else begin
      slice_inc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      strm.s_valid <= 1'b0;
      strm.s_first <= 1'b0;
      strm.s_last  <= 1'b0;
      strm.s_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state        <= HDR;
            strm.s_valid <= 1'b1;
            strm.s_first <= 1'b1;
            strm.s_last  <= 1'b0;
            strm.s_data  <= head.stamp;
          end
        end
        HDR: begin
          if (strm.s_ready) begin
            state        <= DATA;
            beat         <= '0;
            strm.s_first <= 1'b0;
            strm.s_last  <= (NBEATS == 1);
            strm.s_data  <= pad_head[LANE_W-1:0];
          end
        end
        DATA: begin
          if (strm.s_ready) begin
            if (beat == LAST_BEAT) begin
              beat        <= '0;
              strm.s_last <= 1'b0;
              if (more) begin
                state        <= HDR;
                strm.s_first <= 1'b1;
                strm.s_data  <= next_rec.stamp;
              end else begin
                state        <= IDLE;
                strm.s_valid <= 1'b0;
                strm.s_first <= 1'b0;
                strm.s_data  <= '0;
              end
            end else begin
              beat        <= beat_inc;
              strm.s_last <= (beat_inc == LAST_BEAT);
              strm.s_data <= slice_inc;
            end
          end
        end
        default: begin
          state        <= IDLE;
          beat         <= '0;
          strm.s_valid <= 1'b0;
          strm.s_first <= 1'b0;
          strm.s_last  <= 1'b0;
          strm.s_data  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'h0000;
    end else begin
      cyc_cnt <= cyc_cnt + LANE_W'(1);
      if (cap_valid && !push) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'h0001;
        end
      end
    end
  end

endmodule

// File: tb/tb_flat_trace_serializer.sv
// Self-checking bench: table of capture vectors with known beat images,
// a beat scoreboard per DUT, and directed overflow/reset/wrap sequences.
`timescale 1ns/1ps
module tb_flat_trace_serializer;

  logic         clk = 1'b0;
  logic         rst, cap_valid, cap2;
  logic [158:0] flat_in;
  logic [19:0]  flat2;
  logic         overflow, overflow2;
  logic [15:0]  drop_cnt, drop2;
  logic [31:0]  cyc_cnt, mcyc;
  logic [7:0]   cyc2;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  flat_trace_serializer_if #(.LANE_W(32)) sif ();
  flat_trace_serializer_if #(.LANE_W(8))  sif2 ();

  flat_trace_serializer dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .flat_in(flat_in), .strm(sif),
    .overflow(overflow), .drop_cnt(drop_cnt), .cyc_cnt(cyc_cnt)
  );

  flat_trace_serializer #(.W_IN(20), .LANE_W(8), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .cap_valid(cap2), .flat_in(flat2), .strm(sif2),
    .overflow(overflow2), .drop_cnt(drop2), .cyc_cnt(cyc2)
  );

  typedef struct packed { logic [31:0] data; logic first; logic last; } beat_t;
  typedef struct packed { logic [7:0] data; logic first; logic last; } beat2_t;
  typedef struct packed { logic [158:0] vec; logic [4:0][31:0] beats; logic bp; } tv_t;

  beat_t  exp_q[$];
  beat2_t exp2_q[$];
  tv_t    tbl [4];
  logic [3:0] rp = 4'b1001;

  always @(posedge clk) begin
    if (rst) mcyc <= 32'd0;
    else     mcyc <= mcyc + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic  held = 1'b0;
  beat_t held_beat, e1;
  always @(negedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (held) chk("stall_hold", {sif.s_valid, sif.s_data, sif.s_first, sif.s_last}, {1'b1, held_beat});
      if (sif.s_valid && sif.s_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got %h expected no beat", sif.s_data);
        end else begin
          e1 = exp_q.pop_front();
          chk("beat", {sif.s_data, sif.s_first, sif.s_last}, e1);
        end
      end
      held      <= sif.s_valid && !sif.s_ready;
      held_beat <= {sif.s_data, sif.s_first, sif.s_last};
    end
  end

  beat2_t e2;
  always @(negedge clk) begin
    if (!rst && sif2.s_valid && sif2.s_ready) begin
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_beat2: got %h expected no beat", sif2.s_data);
      end else begin
        e2 = exp2_q.pop_front();
        chk("beat2", {sif2.s_data, sif2.s_first, sif2.s_last}, e2);
      end
    end
  end

  task automatic push_rec(input logic [4:0][31:0] b, input logic [31:0] stamp);
    exp_q.push_back({stamp, 1'b1, 1'b0});
    for (int k = 0; k < 5; k++) exp_q.push_back({b[k], 1'b0, (k == 4)});
  endtask

  task automatic capture(input logic [158:0] v, input logic [4:0][31:0] b, input logic [31:0] stamp);
    cap_valid = 1'b1;
    flat_in   = v;
    push_rec(b, stamp);
    @(posedge clk); #1;
    cap_valid = 1'b0;
  endtask

  task automatic drain(input logic bp, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      sif.s_ready = bp ? rp[n % 4] : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    sif.s_ready = 1'b1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_valid", sif.s_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0].vec = 159'h1;
    tbl[0].beats = '0; tbl[0].beats[0] = 32'h00000001; tbl[0].bp = 1'b0;
    tbl[1].vec = '1;
    for (int k = 0; k < 4; k++) tbl[1].beats[k] = 32'hFFFFFFFF;
    tbl[1].beats[4] = 32'h7FFFFFFF; tbl[1].bp = 1'b1;
    tbl[2].vec = {1'b1, 158'h0};
    tbl[2].beats = '0; tbl[2].beats[4] = 32'h40000000; tbl[2].bp = 1'b1;
    tbl[3].vec = {31'h01234567, 32'h89ABCDEF, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D};
    tbl[3].beats[0] = 32'hCAFEF00D; tbl[3].beats[1] = 32'hDEADBEEF; tbl[3].beats[2] = 32'h00000000;
    tbl[3].beats[3] = 32'h89ABCDEF; tbl[3].beats[4] = 32'h01234567; tbl[3].bp = 1'b0;

    rst = 1'b1; cap_valid = 1'b0; cap2 = 1'b0; flat_in = '0; flat2 = '0;
    sif.s_ready = 1'b1; sif2.s_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", sif.s_valid, 1'b0);
    chk("rst_data", sif.s_data, 32'h0);
    chk("rst_first_last", {sif.s_first, sif.s_last}, 2'b00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop", drop_cnt, 16'h0);
    chk("rst_cyc", cyc_cnt, 32'h0);

    // Single capture with stamp 5, then latency and idle afterwards.
    repeat (5) @(posedge clk);
    #1;
    chk("cyc_count", cyc_cnt, 32'd5);
    capture(tbl[2].vec, tbl[2].beats, 32'd5);
    @(posedge clk); #1;
    chk("latency_valid", sif.s_valid, 1'b1);
    chk("hdr_first", sif.s_first, 1'b1);
    drain(1'b0, 200);
    idle_check();

    // Table of vectors, some under 1,0,0,1 back-pressure.
    for (int i = 0; i < 4; i++) begin
      capture(tbl[i].vec, tbl[i].beats, mcyc);
      drain(tbl[i].bp, 300);
      idle_check();
    end

    // Overflow: six captures into a stalled FIFO of four.
    sif.s_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cap_valid = 1'b1;
      flat_in   = tbl[i % 4].vec;
      if (i < 4) push_rec(tbl[i % 4].beats, mcyc);
      @(posedge clk); #1;
    end
    cap_valid = 1'b0;
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drop", drop_cnt, 16'd2);
    begin
      int n = 0;
      sif.s_ready = 1'b1;
      while (exp_q.size() > 0 && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      chk("contig_cycles", n, 24);
    end
    idle_check();

    // Full FIFO: capture lands on the edge that pops the head's last beat.
    sif.s_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'b1;
      flat_in   = tbl[i].vec;
      push_rec(tbl[i].beats, mcyc);
      @(posedge clk); #1;
    end
    cap_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 sif.s_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cap_valid = 1'b1;
    flat_in   = tbl[3].vec;
    push_rec(tbl[3].beats, mcyc);
    @(posedge clk); #1;
    cap_valid = 1'b0;
    chk("fullpop_drop", drop_cnt, 16'd2);
    drain(1'b0, 400);
    idle_check();

    // Reset after three beats of a record.
    capture(tbl[0].vec, tbl[0].beats, mcyc);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_left", exp_q.size(), 3);
    rst = 1'b1;
    exp_q.delete();
    exp2_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", sif.s_valid, 1'b0);
    chk("mid_rst_drop", drop_cnt, 16'h0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_cyc", cyc_cnt, 32'h0);
    @(posedge clk); #1;
    capture(tbl[3].vec, tbl[3].beats, 32'd1);
    drain(1'b0, 200);
    idle_check();

    // Narrow build: stamps 0xFF then 0x00, three beats with zero-padded top.
    begin
      int n = 0;
      while (cyc2 != 8'hFF && n < 600) begin
        @(posedge clk); #1;
        n++;
      end
      chk("wrap_reach", cyc2, 8'hFF);
    end
    cap2 = 1'b1;
    flat2 = 20'hABCDE;
    exp2_q.push_back({8'hFF, 1'b1, 1'b0});
    exp2_q.push_back({8'hDE, 1'b0, 1'b0});
    exp2_q.push_back({8'hBC, 1'b0, 1'b0});
    exp2_q.push_back({8'h0A, 1'b0, 1'b1});
    @(posedge clk); #1;
    flat2 = 20'h12345;
    exp2_q.push_back({8'h00, 1'b1, 1'b0});
    exp2_q.push_back({8'h45, 1'b0, 1'b0});
    exp2_q.push_back({8'h23, 1'b0, 1'b0});
    exp2_q.push_back({8'h01, 1'b0, 1'b1});
    @(posedge clk); #1;
    cap2 = 1'b0;
    begin
      int n = 0;
      while (exp2_q.size() > 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("wrap_drain_left", exp2_q.size(), 0);
    end
    chk("wrap_ovf", overflow2, 1'b0);
    @(negedge clk);
    chk("wrap_idle", sif2.s_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
